imem_access_arbiter: RTL and testbench



---
 rtl/imem_access_arbiter.sv | 127 ++++++++++++
 tb/tb_imem_access_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/imem_access_arbiter.sv
// imem_access_arbiter
//   Shares a single-port, synchronous-read instruction memory between the CPU
//   fetch path (read-only) and the program loader (write-only). At most one
//   requester is granted per cycle; fetch data returns one cycle after grant
//   with a registered valid flag.
//   Optional feature macro: IMEM_ARB_FAIRNESS_EN. When it is defined, a fetch
//   is forced through after MAX_LOAD_BURST consecutive load grants with fetch
//   waiting. When it is undefined, load has strict priority.
module imem_access_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MAX_LOAD_BURST = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              fetch_req_i,
    input  logic [ADDR_W-1:0] fetch_addr_i,
    output logic              fetch_gnt_o,
    output logic              fetch_valid_o,
    output logic [DATA_W-1:0] fetch_rdata_o,
    input  logic              load_req_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic [DATA_W-1:0] load_wdata_i,
    output logic              load_gnt_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              fetch_valid_q;
    logic [DATA_W-1:0] rdata_hold_q;
    logic              force_fetch;

`ifdef IMEM_ARB_FAIRNESS_EN
    localparam int CNT_W = $clog2(MAX_LOAD_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOAD_BURST);

    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;

    // Fetch has waited through a full burst of loads: it takes this cycle.
    assign force_fetch = (run_cnt_q == CNT_MAX) && fetch_req_i;

    // Count load grants that happen while fetch is waiting; saturate at the limit.
    always_comb begin
        run_cnt_d = '0;
        if (load_gnt_o && fetch_req_i) begin
            run_cnt_d = (run_cnt_q == CNT_MAX) ? run_cnt_q : run_cnt_q + 1'b1;
        end
    end

    // Burst counter register.
    always_ff @(posedge clk_i) begin
        if (reset_i) run_cnt_q <= '0;
        else         run_cnt_q <= run_cnt_d;
    end
`else
    assign force_fetch = 1'b0;
`endif

    // Grant selection: load first unless fairness forces a fetch; none in reset.
    always_comb begin
        fetch_gnt_o = 1'b0;
        load_gnt_o  = 1'b0;
        if (!reset_i) begin
            if (load_req_i && !force_fetch) load_gnt_o  = 1'b1;
            else if (fetch_req_i)           fetch_gnt_o = 1'b1;
        end
    end

    // Memory port mux; address and write data hold their last value when idle.
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (load_gnt_o) begin
            mem_addr_d  = {load_addr_i[ADDR_W-1:2], 2'b00};
            mem_wdata_d = load_wdata_i;
        end else if (fetch_gnt_o) begin
            mem_addr_d  = {fetch_addr_i[ADDR_W-1:2], 2'b00};
        end
    end

    assign mem_addr_o  = mem_addr_d;
    assign mem_wdata_o = mem_wdata_d;
    assign mem_we_o    = load_gnt_o;

    // Next state follows whichever grant was issued this cycle.
    always_comb begin
        state_d = IDLE;
        if (load_gnt_o)       state_d = LOAD;
        else if (fetch_gnt_o) state_d = FETCH;
    end

    assign busy_o = (state_q == LOAD) || load_gnt_o;

    // A return in flight when reset arrives is dropped at once.
    assign fetch_valid_o = fetch_valid_q && !reset_i;
    assign fetch_rdata_o = fetch_valid_o ? mem_rdata_i : rdata_hold_q;

    // State, held memory port values and read-return registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            fetch_valid_q <= 1'b0;
            rdata_hold_q  <= '0;
        end else begin
            state_q       <= state_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            fetch_valid_q <= fetch_gnt_o;
            if (fetch_valid_o) rdata_hold_q <= mem_rdata_i;
        end
    end

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Directed bench for imem_access_arbiter with a small synchronous-read memory model.
module tb_imem_access_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req, load_req;
    logic [31:0] fetch_addr, load_addr, load_wdata;
    logic        fetch_gnt, fetch_valid, load_gnt, mem_we, busy;
    logic [31:0] fetch_rdata, mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [0:15];

    int checks = 0;
    int errors = 0;

    imem_access_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LOAD_BURST(4)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .fetch_req_i  (fetch_req),
        .fetch_addr_i (fetch_addr),
        .fetch_gnt_o  (fetch_gnt),
        .fetch_valid_o(fetch_valid),
        .fetch_rdata_o(fetch_rdata),
        .load_req_i   (load_req),
        .load_addr_i  (load_addr),
        .load_wdata_i (load_wdata),
        .load_gnt_o   (load_gnt),
        .mem_addr_o   (mem_addr),
        .mem_we_o     (mem_we),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    // Single-port memory: write on mem_we, registered read of the same address.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[5:2]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[5:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[0] = 32'h20080001;
        mem[1] = 32'h21090002;
        mem[2] = 32'h11111111;
        mem_rdata  = 32'h0;
        reset      = 1'b1;
        fetch_req  = 1'b1;
        load_req   = 1'b1;
        fetch_addr = 32'h0;
        load_addr  = 32'h8;
        load_wdata = 32'h5555AAAA;

        // 1: reset with both requests high
        step(); step(); #3;
        chk("rst_fetch_gnt", 32'(fetch_gnt), 32'd0);
        chk("rst_load_gnt", 32'(load_gnt), 32'd0);
        chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_fetch_rdata", fetch_rdata, 32'h0);

        // 2: back-to-back fetches from 0x0 and 0x6 (low bits ignored)
        step();
        reset = 1'b0; load_req = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h0;
        #3;
        chk("f0_gnt", 32'(fetch_gnt), 32'd1);
        chk("f0_load_gnt", 32'(load_gnt), 32'd0);
        chk("f0_mem_addr", mem_addr, 32'h0);
        chk("f0_mem_we", 32'(mem_we), 32'd0);
        step();
        fetch_addr = 32'h6;
        #3;
        chk("f1_gnt", 32'(fetch_gnt), 32'd1);
        chk("f1_mem_addr", mem_addr, 32'h4);
        chk("f0_valid", 32'(fetch_valid), 32'd1);
        chk("f0_rdata", fetch_rdata, 32'h20080001);
        step();
        fetch_req = 1'b0;
        #3;
        chk("f2_no_gnt", 32'(fetch_gnt), 32'd0);
        chk("f1_valid", 32'(fetch_valid), 32'd1);
        chk("f1_rdata", fetch_rdata, 32'h21090002);
        chk("idle_addr_hold", mem_addr, 32'h4);
        step(); #3;
        chk("idle_valid", 32'(fetch_valid), 32'd0);
        chk("idle_rdata_hold", fetch_rdata, 32'h21090002);

        // 3: load and fetch to the same address; write wins, fetch sees new word
        step();
        load_req = 1'b1; load_addr = 32'h8; load_wdata = 32'hDEADBEEF;
        fetch_req = 1'b1; fetch_addr = 32'h8;
        #3;
        chk("raw_load_gnt", 32'(load_gnt), 32'd1);
        chk("raw_fetch_gnt0", 32'(fetch_gnt), 32'd0);
        chk("raw_mem_we", 32'(mem_we), 32'd1);
        chk("raw_mem_addr", mem_addr, 32'h8);
        chk("raw_mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk("raw_busy0", 32'(busy), 32'd1);
        step();
        load_req = 1'b0;
        #3;
        chk("raw_fetch_gnt1", 32'(fetch_gnt), 32'd1);
        chk("raw_load_gnt1", 32'(load_gnt), 32'd0);
        chk("raw_mem_we1", 32'(mem_we), 32'd0);
        chk("raw_busy1", 32'(busy), 32'd1);
        step();
        fetch_req = 1'b0;
        #3;
        chk("raw_valid", 32'(fetch_valid), 32'd1);
        chk("raw_rdata", fetch_rdata, 32'hDEADBEEF);
        chk("raw_busy2", 32'(busy), 32'd0);

        // 4: both requests held for ten cycles
        step();
        load_req = 1'b1; load_addr = 32'hC; fetch_req = 1'b1; fetch_addr = 32'h0;
        for (int i = 0; i < 10; i++) begin
            logic exp_f;
            load_wdata = 32'hCAFE0000 + 32'(i);
`ifdef IMEM_ARB_FAIRNESS_EN
            exp_f = (i == 4) || (i == 9);
`else
            exp_f = 1'b0;
`endif
            #3;
            chk($sformatf("burst%0d_fetch_gnt", i), 32'(fetch_gnt), 32'(exp_f));
            chk($sformatf("burst%0d_load_gnt", i), 32'(load_gnt), 32'(!exp_f));
            chk($sformatf("burst%0d_busy", i), 32'(busy), 32'd1);
            step();
        end

        // 5: reset pulsed the cycle after a fetch grant
        load_req = 1'b0; fetch_req = 1'b0;
        step();
        fetch_req = 1'b1; fetch_addr = 32'h4;
        #3;
        chk("rp_fetch_gnt", 32'(fetch_gnt), 32'd1);
        step();
        fetch_req = 1'b0; reset = 1'b1;
        #3;
        chk("rp_valid_in_reset", 32'(fetch_valid), 32'd0);
        chk("rp_mem_we", 32'(mem_we), 32'd0);
        chk("rp_busy", 32'(busy), 32'd0);
        step();
        reset = 1'b0;
        #3;
        chk("rp_valid_after", 32'(fetch_valid), 32'd0);
        chk("rp_busy_after", 32'(busy), 32'd0);
        chk("rp_mem_addr", mem_addr, 32'h0);
        chk("rp_rdata", fetch_rdata, 32'h0);
        chk("rp_mem_we_after", 32'(mem_we), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
